// File: rtl/midori_sbox_pipe_ctrl_if.sv
// Handshake/control bundle for the masked Midori S-box pipeline controller.
// master: round/state controller side; slave: the pipeline controller.
interface midori_sbox_pipe_ctrl_if #(
    parameter int STAGES = 4,
    parameter int RAND_W = 6,
    parameter int LFSR_W = 31
);
    logic                         seed_valid;
    logic [LFSR_W-1:0]            seed;
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [STAGES-1:0]            stage_en;
    logic [RAND_W-1:0]            r1;
    logic [RAND_W-1:0]            r2;
    logic [$clog2(STAGES+1)-1:0]  occupancy;
    logic                         busy;

    modport master (
        output seed_valid, seed, flush, in_valid, out_ready,
        input  in_ready, out_valid, stage_en, r1, r2,
        input  occupancy, busy
    );

    modport slave (
        input  seed_valid, seed, flush, in_valid, out_ready,
        output in_ready, out_valid, stage_en, r1, r2,
        output occupancy, busy
    );
endinterface

// File: rtl/midori_sbox_pipe_ctrl.sv
// Sequencer for the 4-stage masked Midori S-box: stage enables, valid
// tracking, in/out handshake and LFSR mask randomness (r1, r2).
// Ports: clk, rst_n (sync, active low), bus (slave modport): seed_valid,
//   seed, flush, in_valid/in_ready, out_valid/out_ready, stage_en, r1, r2,
//   occupancy, busy.
// Optional feature: MIDORI_SBOX_PIPE_RESEED_EN enables reseeding from RUN
//   through a DRAIN state with a seed holding register.
module midori_sbox_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int RAND_W = 6,
    parameter int LFSR_W = 31,
    parameter int WARMUP = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    midori_sbox_pipe_ctrl_if.slave  bus
);
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int CNT_W = $clog2(WARMUP + 2);
    localparam logic [CNT_W-1:0] WARM_LAST =
        CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
        S_DRAIN,
`endif
        S_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  warm_q, warm_d;
    logic [STAGES-1:0] valid_q, valid_d;
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
    logic [LFSR_W-1:0] hold_q, hold_d;
`endif

    logic             adv;
    logic             active;
    logic             in_ready;
    logic [OCC_W-1:0] occ;

    // x^31 + x^28 + 1, Fibonacci, shifting toward the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] l
    );
        return {l[LFSR_W-2:0], l[LFSR_W-1] ^ l[LFSR_W-4]};
    endfunction

    // An all-zero state would lock the LFSR.
    function automatic logic [LFSR_W-1:0] seed_fix(
        input logic [LFSR_W-1:0] s
    );
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end

        adv    = !(valid_q[STAGES-1] && !bus.out_ready);
        active = (state_q == S_RUN);
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
        active = active || (state_q == S_DRAIN);
`endif
        in_ready = (state_q == S_RUN) && adv && !bus.flush;

        state_d = state_q;
        lfsr_d  = lfsr_q;
        warm_d  = warm_q;
        valid_d = valid_q;
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
        hold_d  = hold_q;
`endif

        if (active) begin
            if (adv) begin
                lfsr_d = lfsr_step(lfsr_q);
            end
            if (bus.flush) begin
                valid_d = '0;
            end else if (adv) begin
                valid_d = {valid_q[STAGES-2:0],
                           bus.in_valid && in_ready};
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.seed_valid) begin
                    lfsr_d  = seed_fix(bus.seed);
                    warm_d  = '0;
                    state_d = (WARMUP == 0) ? S_RUN : S_WARM;
                end
            end
            S_WARM: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (warm_q == WARM_LAST) begin
                    warm_d  = '0;
                    state_d = S_RUN;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
                if (bus.seed_valid) begin
                    hold_d = bus.seed;
                end
`endif
            end
            S_RUN: begin
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
                if (bus.seed_valid) begin
                    hold_d  = bus.seed;
                    state_d = S_DRAIN;
                end
`endif
            end
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
            S_DRAIN: begin
                if (bus.seed_valid) begin
                    hold_d = bus.seed;
                end
                // The newest seed wins even on the cycle the pipe empties.
                if (occ == '0) begin
                    lfsr_d  = seed_fix(bus.seed_valid ? bus.seed : hold_q);
                    warm_d  = '0;
                    state_d = (WARMUP == 0) ? S_RUN : S_WARM;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_W'(1);
            warm_q  <= '0;
            valid_q <= '0;
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            warm_q  <= warm_d;
            valid_q <= valid_d;
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.stage_en  = active ? {STAGES{adv}} : '0;
    assign bus.r1        = lfsr_q[RAND_W-1:0];
    assign bus.r2        = lfsr_q[2*RAND_W-1:RAND_W];
    assign bus.occupancy = occ;
    assign bus.busy      = (occ != '0) || (state_q != S_RUN);
endmodule

// File: tb/tb_midori_sbox_pipe_ctrl.sv
// Self-checking bench for midori_sbox_pipe_ctrl: directed scenarios plus
// a randomized phase, compared against an item/age queue reference model.
module tb_midori_sbox_pipe_ctrl;
    localparam int STAGES = 4;
    localparam int RAND_W = 6;
    localparam int LFSR_W = 31;
    localparam int WARMUP = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    midori_sbox_pipe_ctrl_if #(
        .STAGES(STAGES), .RAND_W(RAND_W), .LFSR_W(LFSR_W)
    ) bus ();

    midori_sbox_pipe_ctrl #(
        .STAGES(STAGES), .RAND_W(RAND_W),
        .LFSR_W(LFSR_W), .WARMUP(WARMUP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 warm, 2 run, 3 drain.
    // Each in-flight item is represented by its age (advances seen).
    int              m_mode;
    int              m_warm_left;
    logic [30:0]     m_lfsr;
    logic [30:0]     m_hold;
    int              items[$];

    logic            obs_ir, obs_ov;
    logic [3:0]      obs_se;
    logic [5:0]      obs_r1, obs_r2;
    logic [2:0]      obs_occ;
    logic            obs_busy;

    function automatic logic [30:0] poly_next(input logic [30:0] l);
        logic [30:0] fb;
        fb = ((l >> 30) ^ (l >> 27)) & 31'd1;
        return ((l << 1) | fb) & 31'h7fff_ffff;
    endfunction

    function automatic logic [30:0] fix_seed(input logic [30:0] s);
        return (s == 31'd0) ? 31'd1 : s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_warm_left = 0;
        m_lfsr = 31'd1;
        m_hold = 31'd0;
        items.delete();
    endtask

    task automatic tick(input logic rst, input logic sv,
                        input logic [30:0] sd, input logic fl,
                        input logic iv, input logic orr);
        logic ov, adv, act, ir;
        int   pre_occ;
        rst_n          = rst;
        bus.seed_valid = sv;
        bus.seed       = sd;
        bus.flush      = fl;
        bus.in_valid   = iv;
        bus.out_ready  = orr;
        @(negedge clk);
        ov  = (items.size() > 0) && (items[0] == STAGES);
        adv = !(ov && !orr);
        act = (m_mode == 2) || (m_mode == 3);
        ir  = (m_mode == 2) && adv && !fl;
        obs_ir = bus.in_ready;   obs_ov = bus.out_valid;
        obs_se = bus.stage_en;   obs_r1 = bus.r1;
        obs_r2 = bus.r2;         obs_occ = bus.occupancy;
        obs_busy = bus.busy;
        chk("out_valid", obs_ov, ov);
        chk("in_ready", obs_ir, ir);
        chk("stage_en", obs_se, (act && adv) ? 4'hf : 4'h0);
        chk("r1", obs_r1, m_lfsr[5:0]);
        chk("r2", obs_r2, m_lfsr[11:6]);
        chk("occupancy", obs_occ, items.size());
        chk("busy", obs_busy, (items.size() != 0) || (m_mode != 2));
        pre_occ = items.size();
        if (!rst) begin
            model_reset();
        end else begin
            if (act) begin
                if (adv) m_lfsr = poly_next(m_lfsr);
                if (fl) begin
                    items.delete();
                end else if (adv) begin
                    if (ov) void'(items.pop_front());
                    foreach (items[i]) items[i]++;
                    if (iv && ir) items.push_back(1);
                end
            end
            case (m_mode)
                0: if (sv) begin
                    m_lfsr = fix_seed(sd);
                    m_warm_left = WARMUP;
                    m_mode = (WARMUP == 0) ? 2 : 1;
                end
                1: begin
                    m_lfsr = poly_next(m_lfsr);
                    m_warm_left--;
                    if (m_warm_left == 0) m_mode = 2;
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
                    if (sv) m_hold = sd;
`endif
                end
`ifdef MIDORI_SBOX_PIPE_RESEED_EN
                2: if (sv) begin
                    m_hold = sd;
                    m_mode = 3;
                end
                3: begin
                    if (sv) m_hold = sd;
                    if (pre_occ == 0) begin
                        m_lfsr = fix_seed(m_hold);
                        m_warm_left = WARMUP;
                        m_mode = (WARMUP == 0) ? 2 : 1;
                    end
                end
`endif
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 1);
    endtask

    initial begin : main
        int          n0, first_ov, ov_cnt, peak;
        logic [30:0] g;

        bus.seed_valid = 0; bus.seed = 0; bus.flush = 0;
        bus.in_valid = 0;   bus.out_ready = 1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset values, then seed and warm-up length.
        tick(0, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 1);
        n0 = 0;
        tick(1, 1, 31'h1234567, 0, 0, 1);
        if (!obs_ir) n0++;
        for (int i = 0; i < 60 && !obs_ir; i++) begin
            tick(1, 0, 0, 0, 0, 1);
            if (!obs_ir) n0++;
        end
        chk("warm_len", n0, 33);
        g = 31'h1234567;
        for (int i = 0; i < WARMUP; i++) g = poly_next(g);
        chk("r1_golden", obs_r1, g[5:0]);
        chk("r2_golden", obs_r2, g[11:6]);

        // Back-to-back: 10 accepts with out_ready held high.
        first_ov = -1; ov_cnt = 0; peak = 0;
        for (int i = 0; i < 18; i++) begin
            tick(1, 0, 0, 0, i < 10, 1);
            if (obs_ov) begin
                ov_cnt++;
                if (first_ov < 0) first_ov = i;
            end
            if (int'(obs_occ) > peak) peak = obs_occ;
        end
        chk("b2b_first", first_ov, 4);
        chk("b2b_count", ov_cnt, 10);
        chk("b2b_peak", peak, 4);

        // Fill, stall 5 cycles, release.
        for (int i = 0; i < 9; i++) tick(1, 0, 0, 0, 1, 0);
        chk("stall_occ", obs_occ, 4);
        chk("stall_en", obs_se, 0);
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 0, 0, 0, 1);
            if (obs_ov) ov_cnt++;
        end
        chk("release_count", ov_cnt, 4);

        // Flush at occupancy 3 with in_valid high.
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1, 1);
        chk("flush_ir", obs_ir, 0);
        ov_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 0, 0, 1);
            if (i == 0) chk("flush_occ", obs_occ, 0);
            if (obs_ov) ov_cnt++;
        end
        chk("flush_no_out", ov_cnt, 0);

        // Reset with two items in flight, then reseed with zero.
        tick(1, 0, 0, 0, 1, 1);
        tick(1, 0, 0, 0, 1, 1);
        tick(0, 0, 0, 0, 0, 1);
        ov_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, 0, 0, 0, 1);
            if (obs_ov) ov_cnt++;
        end
        chk("rst_no_out", ov_cnt, 0);
        chk("rst_busy", obs_busy, 1);
        tick(1, 1, 31'd0, 0, 0, 1);
        idle_ticks(WARMUP + 2);

        // seed_valid in RUN with two items in flight.
        tick(1, 0, 0, 0, 1, 1);
        tick(1, 0, 0, 0, 1, 1);
        tick(1, 1, 31'($urandom), 0, 0, 1);
        idle_ticks(WARMUP + 12);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom % 300) != 0,
                 ($urandom % 60) == 0,
                 31'($urandom),
                 ($urandom % 25) == 0,
                 ($urandom % 4) != 0,
                 ($urandom % 3) != 0);
            if (m_mode == 0) tick(1, 1, 31'($urandom), 0, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
